bsg_arb_round_robin_lock: RTL

//   Round-robin arbiter with transaction locking. It shares one downstream resource

---
 rtl/bsg_arb_round_robin_lock.sv | 112 +++++++++++
 1 files changed

// File: rtl/bsg_arb_round_robin_lock.sv
// Round-robin arbiter with transaction locking.
// A grant is combinational from reqs_i. The pointer, the lock owner and the
// IDLE/LOCKED state are registered. A transfer (v_o & yumi_i) with last_i=0
// pins the grant on its owner until a transfer with last_i=1 ends the
// transaction.
module bsg_arb_round_robin_lock #(
    parameter int inputs_p    = 16,
    parameter int lg_inputs_p = $clog2(inputs_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [inputs_p-1:0]    reqs_i,
    input  logic                   ready_i,
    input  logic                   yumi_i,
    input  logic                   last_i,
    output logic [inputs_p-1:0]    grants_o,
    output logic                   v_o,
    output logic [lg_inputs_p-1:0] tag_o,
    output logic                   locked_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [inputs_p-1:0]    one_lp  = {{(inputs_p-1){1'b0}}, 1'b1};
    localparam logic [lg_inputs_p-1:0] last_rst_lp = lg_inputs_p'(inputs_p - 1);

    state_e                 state_q, state_d;
    logic [lg_inputs_p-1:0] last_q, last_d;
    logic [lg_inputs_p-1:0] owner_q, owner_d;

    logic [inputs_p-1:0] mask;
    logic [inputs_p-1:0] masked_reqs;
    logic [inputs_p-1:0] masked_pick;
    logic [inputs_p-1:0] plain_pick;
    logic [inputs_p-1:0] winner;
    logic [inputs_p-1:0] grants_raw;
    logic                xfer;

    // Mask selects requesters strictly above the last served index; the
    // lowest set bit (x & -x) of the masked or unmasked vector is the winner.
    always_comb begin
        mask = '0;
        for (int i = 0; i < inputs_p; i++) begin
            mask[i] = (i > int'(last_q));
        end
        masked_reqs = reqs_i & mask;
        masked_pick = masked_reqs & (~masked_reqs + one_lp);
        plain_pick  = reqs_i & (~reqs_i + one_lp);
        winner      = (masked_reqs != '0) ? masked_pick : plain_pick;
    end

    // Grant selection; reset forces every output low regardless of reqs_i.
    always_comb begin
        grants_raw = '0;
        if (state_q == LOCKED) begin
            if (reqs_i[owner_q] && ready_i) begin
                grants_raw = one_lp << owner_q;
            end
        end else if (ready_i) begin
            grants_raw = winner;
        end
        grants_o = reset_i ? '0 : grants_raw;
        v_o      = |grants_o;
        locked_o = (state_q == LOCKED);
        tag_o    = '0;
        for (int i = 0; i < inputs_p; i++) begin
            if (grants_o[i]) begin
                tag_o = lg_inputs_p'(i);
            end
        end
    end

    assign xfer = v_o & yumi_i;

    // Next-state logic: only a real transfer moves the pointer or the lock.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        if (xfer) begin
            if (state_q == IDLE) begin
                last_d = tag_o;
                if (!last_i) begin
                    state_d = LOCKED;
                    owner_d = tag_o;
                end
            end else if (last_i) begin
                state_d = IDLE;
            end
        end
    end

    // State registers with asynchronous reset; index 0 leads after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            last_q  <= last_rst_lp;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // Consuming a beat that was never granted is a protocol error.
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
